// File: rtl/issue_queue.sv
// In-order issue queue with operand capture.
// Renamed instructions enter up to IN_LANES per cycle into a circular buffer.
// Pending operands snoop the result broadcast ports until they hold a value.
// The head entry issues over a valid/ready handshake once both operands are ready.
module issue_queue #(
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 4,
  parameter int DEPTH    = 8,
  parameter int IN_LANES = 4,
  parameter int BC_PORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [$clog2(IN_LANES+1)-1:0]    in_count,
  output logic                             in_ready,
  input  logic [IN_LANES*4-1:0]            in_opcode,
  input  logic [IN_LANES*4-1:0]            in_rt,
  input  logic [IN_LANES-1:0]              in_a_rdy,
  input  logic [IN_LANES*DATA_W-1:0]       in_a_value,
  input  logic [IN_LANES*TAG_W-1:0]        in_a_tag,
  input  logic [IN_LANES-1:0]              in_b_rdy,
  input  logic [IN_LANES*DATA_W-1:0]       in_b_value,
  input  logic [IN_LANES*TAG_W-1:0]        in_b_tag,
  input  logic [BC_PORTS-1:0]              bc_valid,
  input  logic [BC_PORTS*TAG_W-1:0]        bc_tag,
  input  logic [BC_PORTS*DATA_W-1:0]       bc_value,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [3:0]                       out_opcode,
  output logic [3:0]                       out_rt,
  output logic [DATA_W-1:0]                out_a_value,
  output logic [DATA_W-1:0]                out_b_value,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [3:0]        op;
    logic [3:0]        rt;
    logic              a_rdy;
    logic [DATA_W-1:0] a_val;
    logic [TAG_W-1:0]  a_tag;
    logic              b_rdy;
    logic [DATA_W-1:0] b_val;
    logic [TAG_W-1:0]  b_tag;
  } entry_t;

  entry_t          mem_reg  [DEPTH];
  entry_t          mem_next [DEPTH];
  entry_t          lane_ent [IN_LANES];
  entry_t          head_ent;
  logic [PW-1:0]   head_reg, tail_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            enq, deq, head_live;

  // Returns {rdy, value} after snooping the broadcast ports; scanning from the
  // highest port down lets the lowest matching port have the final word.
  function automatic logic [DATA_W:0] wake(
    input logic                       rdy,
    input logic [TAG_W-1:0]           tag,
    input logic [DATA_W-1:0]          val,
    input logic [BC_PORTS-1:0]        v,
    input logic [BC_PORTS*TAG_W-1:0]  t,
    input logic [BC_PORTS*DATA_W-1:0] d
  );
    logic [DATA_W:0] r;
    r = {rdy, val};
    if (!rdy) begin
      for (int p = BC_PORTS - 1; p >= 0; p--) begin
        if (v[p] && (t[p*TAG_W +: TAG_W] == tag)) begin
          r = {1'b1, d[p*DATA_W +: DATA_W]};
        end
      end
    end
    return r;
  endfunction

  // Incoming lanes, with same-cycle broadcast bypass applied before storage.
  for (genvar gi = 0; gi < IN_LANES; gi++) begin : g_lane
    logic [DATA_W:0] a_w, b_w;
    assign a_w = wake(in_a_rdy[gi], in_a_tag[gi*TAG_W +: TAG_W],
                      in_a_value[gi*DATA_W +: DATA_W], bc_valid, bc_tag, bc_value);
    assign b_w = wake(in_b_rdy[gi], in_b_tag[gi*TAG_W +: TAG_W],
                      in_b_value[gi*DATA_W +: DATA_W], bc_valid, bc_tag, bc_value);
    assign lane_ent[gi] = {in_opcode[gi*4 +: 4], in_rt[gi*4 +: 4],
                           a_w[DATA_W], a_w[DATA_W-1:0], in_a_tag[gi*TAG_W +: TAG_W],
                           b_w[DATA_W], b_w[DATA_W-1:0], in_b_tag[gi*TAG_W +: TAG_W]};
  end

  // in_ready looks only at the registered occupancy, never at a same-cycle dequeue.
  assign in_ready  = (int'(count_reg) + IN_LANES) <= DEPTH;
  assign enq       = in_valid & in_ready;
  assign head_ent  = mem_reg[head_reg];
  assign head_live = (count_reg != '0);
  assign out_valid = head_live & head_ent.a_rdy & head_ent.b_rdy;
  assign deq       = out_valid & out_ready;

  // Data outputs read as zero whenever the queue is empty, so stale slots never show.
  assign out_opcode  = head_live ? head_ent.op    : '0;
  assign out_rt      = head_live ? head_ent.rt    : '0;
  assign out_a_value = head_live ? head_ent.a_val : '0;
  assign out_b_value = head_live ? head_ent.b_val : '0;
  assign count       = count_reg;

  assign count_next = count_reg + (enq ? CW'(in_count) : CW'(0)) - (deq ? CW'(1) : CW'(0));

  // Next entry contents: wakeup on every slot, retire the head, then enqueue writes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_next[i] = mem_reg[i];
      {mem_next[i].a_rdy, mem_next[i].a_val} =
        wake(mem_reg[i].a_rdy, mem_reg[i].a_tag, mem_reg[i].a_val, bc_valid, bc_tag, bc_value);
      {mem_next[i].b_rdy, mem_next[i].b_val} =
        wake(mem_reg[i].b_rdy, mem_reg[i].b_tag, mem_reg[i].b_val, bc_valid, bc_tag, bc_value);
    end
    if (deq) begin
      mem_next[head_reg].a_rdy = 1'b0;
      mem_next[head_reg].b_rdy = 1'b0;
    end
    if (enq) begin
      for (int l = 0; l < IN_LANES; l++) begin
        if (l < int'(in_count)) begin
          mem_next[PW'(tail_reg + PW'(l))] = lane_ent[l];
        end
      end
    end
  end

  // State update; reset and flush both empty the queue and clear every rdy bit.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i].a_rdy <= 1'b0;
        mem_reg[i].b_rdy <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= mem_next[i];
      end
      if (enq) tail_reg <= tail_reg + PW'(in_count);
      if (deq) head_reg <= head_reg + PW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Testbench for issue_queue: table-driven occupancy vectors plus hand-written
// wakeup, bypass, flush and reset sequences, with a scoreboard of issued data.
module tb_issue_queue;

  localparam int DATA_W   = 16;
  localparam int TAG_W    = 4;
  localparam int DEPTH    = 8;
  localparam int IN_LANES = 4;
  localparam int BC_PORTS = 2;

  logic                          clk = 1'b0;
  logic                          rst, flush, in_valid, in_ready;
  logic [2:0]                    in_count;
  logic [IN_LANES*4-1:0]         in_opcode, in_rt;
  logic [IN_LANES-1:0]           in_a_rdy, in_b_rdy;
  logic [IN_LANES*DATA_W-1:0]    in_a_value, in_b_value;
  logic [IN_LANES*TAG_W-1:0]     in_a_tag, in_b_tag;
  logic [BC_PORTS-1:0]           bc_valid;
  logic [BC_PORTS*TAG_W-1:0]     bc_tag;
  logic [BC_PORTS*DATA_W-1:0]    bc_value;
  logic                          out_valid, out_ready;
  logic [3:0]                    out_opcode, out_rt;
  logic [DATA_W-1:0]             out_a_value, out_b_value;
  logic [3:0]                    count;

  issue_queue #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .IN_LANES(IN_LANES), .BC_PORTS(BC_PORTS)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_count(in_count),
    .in_ready(in_ready), .in_opcode(in_opcode), .in_rt(in_rt),
    .in_a_rdy(in_a_rdy), .in_a_value(in_a_value), .in_a_tag(in_a_tag),
    .in_b_rdy(in_b_rdy), .in_b_value(in_b_value), .in_b_tag(in_b_tag),
    .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_value(bc_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_rt(out_rt),
    .out_a_value(out_a_value), .out_b_value(out_b_value), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rt;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  typedef struct {
    int n;
    bit accept;
    bit oready;
    int a_base;
    int exp_count;
    bit exp_valid;
    bit exp_in_ready;
  } vec_t;

  exp_t sb[$];
  exp_t lane_exp[IN_LANES];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_issued = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_count = '0;
    in_opcode = '0; in_rt = '0; in_a_rdy = '1; in_b_rdy = '1;
    in_a_value = '0; in_b_value = '0; in_a_tag = '0; in_b_tag = '0;
    bc_valid = '0; bc_tag = '0; bc_value = '0;
  endtask

  // aval is the value the instruction must issue with; when not ready the
  // lane carries junk and the value has to arrive by broadcast.
  task automatic set_lane(input int l, input logic [3:0] op, input logic [3:0] rt, input bit ardy,
                          input logic [15:0] aval, input logic [3:0] atag, input logic [15:0] bval);
    in_opcode[l*4 +: 4]    = op;
    in_rt[l*4 +: 4]        = rt;
    in_a_rdy[l]            = ardy;
    in_a_value[l*16 +: 16] = ardy ? aval : 16'hDEAD;
    in_a_tag[l*4 +: 4]     = atag;
    in_b_rdy[l]            = 1'b1;
    in_b_value[l*16 +: 16] = bval;
    in_b_tag[l*4 +: 4]     = 4'd0;
    lane_exp[l]            = '{op: op, rt: rt, a: aval, b: bval};
  endtask

  task automatic enq(input int n, input bit accept);
    in_valid = 1'b1;
    in_count = 3'(n);
    if (accept) begin
      for (int l = 0; l < n; l++) sb.push_back(lane_exp[l]);
    end
  endtask

  // One clock: score a handshake seen before the edge, then advance.
  task automatic cycle();
    exp_t e;
    if (out_valid && out_ready) begin
      n_issued++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got op=%0h a=%0h, expected no issue", out_opcode, out_a_value);
      end else begin
        e = sb.pop_front();
        $display("issue %0d: op=%0h rt=%0h a=%04h b=%04h", n_issued, out_opcode, out_rt, out_a_value, out_b_value);
        chk("issue_op", 32'(out_opcode), 32'(e.op));
        chk("issue_rt", 32'(out_rt), 32'(e.rt));
        chk("issue_a", 32'(out_a_value), 32'(e.a));
        chk("issue_b", 32'(out_b_value), 32'(e.b));
      end
    end
    @(posedge clk);
    #1;
    if (flush || rst) sb.delete();
  endtask

  task automatic expect_state(input string name, input int c, input bit v, input bit r);
    chk({name, "_count"}, 32'(count), 32'(c));
    chk({name, "_out_valid"}, 32'(out_valid), 32'(v));
    chk({name, "_in_ready"}, 32'(in_ready), 32'(r));
  endtask

  initial begin
    // n, accept, oready, a_base, exp_count, exp_valid, exp_in_ready
    vecs.push_back('{4, 1, 1, 'h001, 4, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     3, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     2, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     1, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     0, 0, 1});
    vecs.push_back('{4, 1, 0, 'h100, 4, 1, 1});
    vecs.push_back('{4, 1, 0, 'h200, 8, 1, 0});
    vecs.push_back('{4, 0, 0, 'h300, 8, 1, 0});
    vecs.push_back('{0, 0, 1, 0,     7, 1, 0});
    vecs.push_back('{0, 0, 1, 0,     6, 1, 0});
    vecs.push_back('{0, 0, 1, 0,     5, 1, 0});
    vecs.push_back('{0, 0, 1, 0,     4, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     3, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     2, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     1, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     0, 0, 1});
    vecs.push_back('{4, 1, 0, 'h400, 4, 1, 1});
    vecs.push_back('{1, 1, 0, 'h500, 5, 1, 0});
    vecs.push_back('{3, 0, 1, 'h600, 4, 1, 1});
    vecs.push_back('{3, 1, 1, 'h700, 6, 1, 0});
    vecs.push_back('{0, 0, 1, 0,     5, 1, 0});
    vecs.push_back('{0, 0, 1, 0,     4, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     3, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     2, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     1, 1, 1});
    vecs.push_back('{0, 0, 1, 0,     0, 0, 1});

    // Reset
    idle_inputs();
    out_ready = 1'b0;
    rst = 1'b1;
    cycle();
    idle_inputs();
    expect_state("reset", 0, 0, 1);
    chk("reset_out_opcode", 32'(out_opcode), 32'h0);
    chk("reset_out_a_value", 32'(out_a_value), 32'h0);

    // Table-driven occupancy, order and wrap vectors
    for (int i = 0; i < vecs.size(); i++) begin
      idle_inputs();
      out_ready = vecs[i].oready;
      if (vecs[i].n > 0) begin
        for (int l = 0; l < vecs[i].n; l++)
          set_lane(l, 4'(l + 1), 4'(i), 1'b1, 16'(vecs[i].a_base + l), 4'd0, 16'h0010);
        enq(vecs[i].n, vecs[i].accept);
      end
      cycle();
      expect_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_valid, vecs[i].exp_in_ready);
    end

    // Wakeup of a blocked head by port 1; the ready younger entry waits behind it
    idle_inputs();
    out_ready = 1'b1;
    set_lane(0, 4'hA, 4'h1, 1'b0, 16'hBEEF, 4'd5, 16'h0001);
    set_lane(1, 4'hB, 4'h2, 1'b1, 16'h0042, 4'd0, 16'h0002);
    enq(2, 1'b1);
    cycle();
    expect_state("wake_enq", 2, 0, 1);
    idle_inputs();
    cycle();
    expect_state("wake_wait", 2, 0, 1);
    idle_inputs();
    bc_valid = 2'b11;
    bc_tag   = {4'd5, 4'd7};
    bc_value = {16'hBEEF, 16'h7777};
    cycle();
    expect_state("wake_bc", 2, 1, 1);
    idle_inputs();
    cycle();
    expect_state("wake_deq1", 1, 1, 1);
    idle_inputs();
    cycle();
    expect_state("wake_deq2", 0, 0, 1);

    // Enqueue bypass with both ports matching: port 0 wins
    idle_inputs();
    set_lane(0, 4'h3, 4'h3, 1'b0, 16'h1111, 4'd3, 16'h0003);
    bc_valid = 2'b11;
    bc_tag   = {4'd3, 4'd3};
    bc_value = {16'h2222, 16'h1111};
    enq(1, 1'b1);
    cycle();
    expect_state("bypass", 1, 1, 1);
    idle_inputs();
    cycle();
    expect_state("bypass_deq", 0, 0, 1);

    // Stored-entry wakeup with both ports matching: port 0 wins
    idle_inputs();
    set_lane(0, 4'h4, 4'h4, 1'b0, 16'h3333, 4'd9, 16'h0004);
    enq(1, 1'b1);
    cycle();
    expect_state("wake2_enq", 1, 0, 1);
    idle_inputs();
    bc_valid = 2'b11;
    bc_tag   = {4'd9, 4'd9};
    bc_value = {16'h4444, 16'h3333};
    cycle();
    expect_state("wake2_bc", 1, 1, 1);
    idle_inputs();
    cycle();
    expect_state("wake2_deq", 0, 0, 1);

    // Flush with a pending enqueue and a same-cycle handshake
    idle_inputs();
    out_ready = 1'b0;
    set_lane(0, 4'h5, 4'h5, 1'b1, 16'h5000, 4'd0, 16'h0050);
    set_lane(1, 4'h6, 4'h6, 1'b1, 16'h5001, 4'd0, 16'h0051);
    enq(2, 1'b1);
    cycle();
    expect_state("flush_fill", 2, 1, 1);
    idle_inputs();
    out_ready = 1'b1;
    flush = 1'b1;
    set_lane(0, 4'h7, 4'h7, 1'b1, 16'h6000, 4'd0, 16'h0060);
    set_lane(1, 4'h8, 4'h8, 1'b1, 16'h6001, 4'd0, 16'h0061);
    enq(2, 1'b0);
    cycle();
    expect_state("flush", 0, 0, 1);
    idle_inputs();
    set_lane(0, 4'hC, 4'hC, 1'b1, 16'h7000, 4'd0, 16'h0070);
    enq(1, 1'b1);
    cycle();
    expect_state("flush_after", 1, 1, 1);
    idle_inputs();
    cycle();
    expect_state("flush_drain", 0, 0, 1);

    // Reset mid-stream with six entries and a pending broadcast
    idle_inputs();
    out_ready = 1'b0;
    set_lane(0, 4'h1, 4'h1, 1'b1, 16'h8000, 4'd0, 16'h0080);
    set_lane(1, 4'h2, 4'h2, 1'b0, 16'h8888, 4'd2, 16'h0081);
    set_lane(2, 4'h3, 4'h3, 1'b1, 16'h8002, 4'd0, 16'h0082);
    set_lane(3, 4'h4, 4'h4, 1'b1, 16'h8003, 4'd0, 16'h0083);
    enq(4, 1'b1);
    cycle();
    expect_state("rst_fill1", 4, 1, 1);
    idle_inputs();
    set_lane(0, 4'h5, 4'h5, 1'b1, 16'h8100, 4'd0, 16'h0084);
    set_lane(1, 4'h6, 4'h6, 1'b1, 16'h8101, 4'd0, 16'h0085);
    enq(2, 1'b1);
    cycle();
    expect_state("rst_fill2", 6, 1, 0);
    idle_inputs();
    rst = 1'b1;
    bc_valid = 2'b01;
    bc_tag   = {4'd0, 4'd2};
    bc_value = {16'h0000, 16'h8888};
    cycle();
    expect_state("rst_mid", 0, 0, 1);
    chk("rst_out_opcode", 32'(out_opcode), 32'h0);
    chk("rst_out_a_value", 32'(out_a_value), 32'h0);
    chk("rst_out_b_value", 32'(out_b_value), 32'h0);
    idle_inputs();
    out_ready = 1'b1;
    bc_valid = 2'b01;
    bc_tag   = {4'd0, 4'd2};
    bc_value = {16'h0000, 16'h8888};
    cycle();
    expect_state("rst_stale", 0, 0, 1);
    idle_inputs();
    set_lane(0, 4'h9, 4'h9, 1'b1, 16'h9000, 4'd0, 16'h9001);
    enq(1, 1'b1);
    cycle();
    expect_state("rst_new", 1, 1, 1);
    idle_inputs();
    cycle();
    expect_state("rst_new_drain", 0, 0, 1);

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
